ifetch_queue: RTL and testbench

Instruction prefetch queue downstream of the 4-bit program control unit slices. It takes the microprogram address the sequencer drives on its Y bus and issues one read at a time to the control store over a req/ack handshake. It buffers returned words, tagged with their address, in a small FIFO for the decode stage. Back-pressure (`addr_rdy`) tells the sequencer controller when to issue a suspend (hold PC) instruction; `flush` discards prefetched work on jumps, returns and resets.

---
 rtl/ifetch_queue.sv | 144 ++++++++++++++
 tb/tb_ifetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between the sequencer Y bus and the decoder.
// Issues one control-store read at a time over a req/ack handshake. Returned words,
// tagged with their address, go into a DEPTH-entry FIFO.
// Optional feature macro: IFETCHQ_BYPASS_EN. When it is defined, a word returning
// into an empty queue is presented to the decoder in the same cycle.
module ifetch_queue #(
   parameter int unsigned AW    = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     cp,
   input  logic                     clr_,
   input  logic [AW-1:0]            addr,
   input  logic                     addr_vld,
   output logic                     addr_rdy,
   input  logic                     flush,
   output logic [AW-1:0]            mem_a,
   output logic                     mem_rd,
   input  logic                     mem_ack,
   input  logic [DW-1:0]            mem_d,
   output logic [DW-1:0]            ins_d,
   output logic [AW-1:0]            ins_a,
   output logic                     ins_vld,
   input  logic                     ins_rdy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full_,
   output logic                     empty_
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

   state_e          state_q;
   logic [AW-1:0]   mem_a_q;
   logic            mem_rd_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [CW-1:0]   count_q;
   logic [AW-1:0]   ent_a [DEPTH];
   logic [DW-1:0]   ent_d [DEPTH];

   logic            q_empty;
   logic            ack_keep;
   logic            push;
   logic            pop;
   logic            accept;

   assign q_empty  = (count_q == '0);
   assign addr_rdy = (state_q == StIdle) & (count_q < DepthC) & ~flush;
   assign accept   = addr_vld & addr_rdy;
   // A returning word is kept only in REQ and only when no flush is discarding it.
   assign ack_keep = (state_q == StReq) & mem_ack & ~flush;
   assign pop      = ~q_empty & ins_rdy & ~flush;

   assign mem_a    = mem_a_q;
   assign mem_rd   = mem_rd_q;
   assign count    = count_q;
   assign full_    = (count_q != DepthC);
   assign empty_   = ~q_empty;

   // Head presentation and push decision (bypass forwards an ack straight to the decoder).
   always_comb begin
      ins_a   = ent_a[rd_ptr_q];
      ins_d   = ent_d[rd_ptr_q];
      ins_vld = ~q_empty;
      push    = ack_keep;
`ifdef IFETCHQ_BYPASS_EN
      if (ack_keep && q_empty) begin
         ins_vld = 1'b1;
         ins_a   = mem_a_q;
         ins_d   = mem_d;
         push    = ~ins_rdy;
      end
`endif
   end

   // Fetch FSM with registered read request and address.
   always_ff @(posedge cp) begin
      if (!clr_) begin
         state_q  <= StIdle;
         mem_rd_q <= 1'b0;
         mem_a_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  mem_a_q  <= addr;
                  mem_rd_q <= 1'b1;
                  state_q  <= StReq;
               end
            end
            StReq: begin
               if (mem_ack) begin
                  mem_rd_q <= 1'b0;
                  state_q  <= StIdle;
               end else if (flush) begin
                  // The request stays up until acked; its data will be thrown away.
                  state_q  <= StDrop;
               end
            end
            StDrop: begin
               if (mem_ack) begin
                  mem_rd_q <= 1'b0;
                  state_q  <= StIdle;
               end
            end
            default: begin
               state_q  <= StIdle;
               mem_rd_q <= 1'b0;
            end
         endcase
      end
   end

   // Queue pointers and occupancy; flush clears everything ahead of push/pop.
   always_ff @(posedge cp) begin
      if (!clr_) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge cp) begin
      if (clr_ && push) begin
         ent_a[wr_ptr_q] <= mem_a_q;
         ent_d[wr_ptr_q] <= mem_d;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: fixed vector table, directed corner sequences,
// then random traffic checked against a queue-based reference model.
module tb_ifetch_queue;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic            cp = 1'b0;
   logic            clr_ = 1'b0;
   logic [AW-1:0]   addr = '0;
   logic            addr_vld = 1'b0;
   logic            addr_rdy;
   logic            flush = 1'b0;
   logic [AW-1:0]   mem_a;
   logic            mem_rd;
   logic            mem_ack = 1'b0;
   logic [DW-1:0]   mem_d = '0;
   logic [DW-1:0]   ins_d;
   logic [AW-1:0]   ins_a;
   logic            ins_vld;
   logic            ins_rdy = 1'b0;
   logic [$clog2(DEPTH):0] count;
   logic            full_;
   logic            empty_;

   int n_vec = 0;
   int n_bad = 0;

   ifetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .cp(cp), .clr_(clr_), .addr(addr), .addr_vld(addr_vld), .addr_rdy(addr_rdy),
      .flush(flush), .mem_a(mem_a), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_d(mem_d),
      .ins_d(ins_d), .ins_a(ins_a), .ins_vld(ins_vld), .ins_rdy(ins_rdy), .count(count),
      .full_(full_), .empty_(empty_)
   );

   always #5 cp = ~cp;

   // Reference model: one outstanding read (busy/discard) and a FIFO of {addr, data}.
   bit              m_known = 0;
   bit              m_busy = 0;
   bit              m_drop = 0;
   logic [AW-1:0]   m_a = '0;
   logic [AW-1:0]   mq_a[$];
   logic [DW-1:0]   mq_d[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs are already driven; check pre-edge addr_rdy, advance model, clock, check state.
   task automatic tick();
      bit exp_rdy;
      bit was_busy;
      #1;
      exp_rdy = !m_busy && (mq_a.size() < DEPTH) && !flush;
      if (m_known && clr_) chk("addr_rdy_pre", {31'd0, addr_rdy}, {31'd0, exp_rdy});
      if (!clr_) begin
         m_known = 1; m_busy = 0; m_drop = 0; m_a = '0;
         mq_a.delete(); mq_d.delete();
      end else if (m_known) begin
         was_busy = m_busy;
         if (flush) begin
            mq_a.delete(); mq_d.delete();
            if (m_busy) begin
               if (mem_ack) begin m_busy = 0; m_drop = 0; end
               else m_drop = 1;
            end
         end else begin
            if (mq_a.size() != 0 && ins_rdy) begin
               void'(mq_a.pop_front());
               void'(mq_d.pop_front());
            end
            if (m_busy && mem_ack) begin
               if (!m_drop) begin mq_a.push_back(m_a); mq_d.push_back(mem_d); end
               m_busy = 0; m_drop = 0;
            end
            if (!was_busy && addr_vld && exp_rdy) begin m_busy = 1; m_a = addr; end
         end
      end
      @(posedge cp);
      #1;
      if (m_known) begin
         chk("count", 32'(count), 32'(mq_a.size()));
         chk("ins_vld", {31'd0, ins_vld}, {31'd0, mq_a.size() != 0});
         chk("full_", {31'd0, full_}, {31'd0, mq_a.size() != DEPTH});
         chk("empty_", {31'd0, empty_}, {31'd0, mq_a.size() != 0});
         chk("mem_rd", {31'd0, mem_rd}, {31'd0, m_busy});
         chk("mem_a", 32'(mem_a), 32'(m_a));
         if (mq_a.size() != 0) begin
            chk("ins_a", 32'(ins_a), 32'(mq_a[0]));
            chk("ins_d", 32'(ins_d), 32'(mq_d[0]));
         end
      end
   endtask

   task automatic drive(input logic c, input logic [AW-1:0] a, input logic av, input logic fl,
                        input logic ack, input logic [DW-1:0] md, input logic ir);
      clr_ = c; addr = a; addr_vld = av; flush = fl; mem_ack = ack; mem_d = md; ins_rdy = ir;
   endtask

   typedef struct {
      logic c; logic [3:0] a; logic av; logic fl; logic ack; logic [15:0] md; logic ir;
      int cnt; logic vld; logic rd; logic [3:0] ma; logic [3:0] ia; logic [15:0] id; logic rdy;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic c, input logic [3:0] a, input logic av, input logic fl,
                      input logic ack, input logic [15:0] md, input logic ir, input int cnt,
                      input logic vld, input logic rd, input logic [3:0] ma,
                      input logic [3:0] ia, input logic [15:0] id, input logic rdy);
      vec_t v;
      v.c = c; v.a = a; v.av = av; v.fl = fl; v.ack = ack; v.md = md; v.ir = ir;
      v.cnt = cnt; v.vld = vld; v.rd = rd; v.ma = ma; v.ia = ia; v.id = id; v.rdy = rdy;
      tbl.push_back(v);
   endtask

   initial begin
      int last_a;
      // Reset, single fetch of 3 -> A5C3, then pop.
      //   c  a   av fl ack md        ir   cnt vld rd ma   ia   id        rdy
      add(0, 0,  0, 0, 0, 16'h0000, 0,   0,  0,  0, 0,   0,   16'h0000, 1);
      add(0, 0,  0, 0, 0, 16'h0000, 0,   0,  0,  0, 0,   0,   16'h0000, 1);
      add(1, 3,  1, 0, 0, 16'h0000, 0,   0,  0,  1, 3,   0,   16'h0000, 0);
      add(1, 0,  0, 0, 1, 16'hA5C3, 0,   1,  1,  0, 3,   3,   16'hA5C3, 1);
      add(1, 0,  0, 0, 0, 16'h0000, 1,   0,  0,  0, 3,   0,   16'h0000, 1);
      // Fill with addresses 0..3, zero-wait memory, decoder stalled.
      add(1, 0,  1, 0, 0, 16'h0000, 0,   0,  0,  1, 0,   0,   16'h0000, 0);
      add(1, 0,  0, 0, 1, 16'h1000, 0,   1,  1,  0, 0,   0,   16'h1000, 1);
      add(1, 1,  1, 0, 0, 16'h0000, 0,   1,  1,  1, 1,   0,   16'h1000, 0);
      add(1, 0,  0, 0, 1, 16'h1001, 0,   2,  1,  0, 1,   0,   16'h1000, 1);
      add(1, 2,  1, 0, 0, 16'h0000, 0,   2,  1,  1, 2,   0,   16'h1000, 0);
      add(1, 0,  0, 0, 1, 16'h1002, 0,   3,  1,  0, 2,   0,   16'h1000, 1);
      add(1, 3,  1, 0, 0, 16'h0000, 0,   3,  1,  1, 3,   0,   16'h1000, 0);
      add(1, 0,  0, 0, 1, 16'h1003, 0,   4,  1,  0, 3,   0,   16'h1000, 0);
      add(1, 4,  1, 0, 0, 16'h0000, 0,   4,  1,  0, 3,   0,   16'h1000, 0);
      add(1, 0,  0, 0, 0, 16'h0000, 1,   3,  1,  0, 3,   1,   16'h1001, 1);
      add(1, 0,  0, 1, 0, 16'h0000, 0,   0,  0,  0, 3,   0,   16'h0000, 0);
      add(1, 0,  0, 0, 0, 16'h0000, 0,   0,  0,  0, 3,   0,   16'h0000, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].c, tbl[i].a, tbl[i].av, tbl[i].fl, tbl[i].ack, tbl[i].md, tbl[i].ir);
         tick();
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_vld", i), {31'd0, ins_vld}, {31'd0, tbl[i].vld});
         chk($sformatf("tbl%0d_rd", i), {31'd0, mem_rd}, {31'd0, tbl[i].rd});
         chk($sformatf("tbl%0d_ma", i), 32'(mem_a), 32'(tbl[i].ma));
         chk($sformatf("tbl%0d_rdy", i), {31'd0, addr_rdy}, {31'd0, tbl[i].rdy});
         chk($sformatf("tbl%0d_full_", i), {31'd0, full_}, {31'd0, tbl[i].cnt != DEPTH});
         chk($sformatf("tbl%0d_empty_", i), {31'd0, empty_}, {31'd0, tbl[i].cnt != 0});
         if (tbl[i].vld) begin
            chk($sformatf("tbl%0d_ia", i), 32'(ins_a), 32'(tbl[i].ia));
            chk($sformatf("tbl%0d_id", i), 32'(ins_d), 32'(tbl[i].id));
         end
      end

      // Pointer wrap: 10 streamed fetches with the decoder always ready.
      last_a = -1;
      for (int i = 0; i < 10; i++) begin
         drive(1, AW'(i), 1, 0, 0, 16'h0, 1);
         tick();
         drive(1, 0, 0, 0, 1, 16'h2000 + 16'(i), 1);
         tick();
         chk("wrap_vld", {31'd0, ins_vld}, 32'd1);
         chk("wrap_ia", 32'(ins_a), 32'(i));
         chk("wrap_id", 32'(ins_d), 32'h2000 + 32'(i));
         chk("wrap_order", {31'd0, int'(ins_a) == last_a + 1}, 32'd1);
         last_a = int'(ins_a);
      end
      drive(1, 0, 0, 0, 0, 16'h0, 1);
      tick();
      chk("wrap_drain", 32'(count), 32'd0);

      // Flush while a read is in flight; ack arrives 3 cycles after the request.
      drive(1, 5, 1, 0, 0, 16'h0, 0);
      tick();
      drive(1, 0, 0, 1, 0, 16'h0, 0);
      tick();
      chk("fl_rd_held0", {31'd0, mem_rd}, 32'd1);
      chk("fl_rdy_drop", {31'd0, addr_rdy}, 32'd0);
      drive(1, 0, 0, 0, 0, 16'h0, 0);
      tick();
      chk("fl_rd_held1", {31'd0, mem_rd}, 32'd1);
      drive(1, 0, 0, 0, 1, 16'hDEAD, 0);
      tick();
      chk("fl_rd_drop", {31'd0, mem_rd}, 32'd0);
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_vld", {31'd0, ins_vld}, 32'd0);
      drive(1, 6, 1, 0, 0, 16'h0, 0);
      tick();
      drive(1, 0, 0, 0, 1, 16'h6666, 0);
      tick();
      chk("fl_next_ia", 32'(ins_a), 32'd6);
      chk("fl_next_id", 32'(ins_d), 32'h6666);

      // Flush coinciding with an ack while two words are queued.
      drive(1, 7, 1, 0, 0, 16'h0, 0);
      tick();
      drive(1, 0, 0, 0, 1, 16'h7777, 0);
      tick();
      chk("fa_count2", 32'(count), 32'd2);
      drive(1, 8, 1, 0, 0, 16'h0, 0);
      tick();
      drive(1, 0, 0, 1, 1, 16'hBAD0, 0);
      tick();
      chk("fa_count", 32'(count), 32'd0);
      chk("fa_vld", {31'd0, ins_vld}, 32'd0);
      chk("fa_rd", {31'd0, mem_rd}, 32'd0);
      drive(1, 0, 0, 0, 0, 16'h0, 1);
      tick();
      chk("fa_idle", {31'd0, addr_rdy}, 32'd1);
      chk("fa_no_stale", {31'd0, ins_vld}, 32'd0);

      // Reset mid-request; a late ack must be ignored.
      drive(1, 9, 1, 0, 0, 16'h0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 16'h0, 0);
      tick();
      chk("rst_rd", {31'd0, mem_rd}, 32'd0);
      chk("rst_ma", 32'(mem_a), 32'd0);
      drive(1, 0, 0, 0, 1, 16'hBEEF, 0);
      tick();
      chk("rst_late_ack", 32'(count), 32'd0);
      chk("rst_late_vld", {31'd0, ins_vld}, 32'd0);
      chk("rst_rdy", {31'd0, addr_rdy}, 32'd1);

      // Random traffic against the reference model.
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 99) != 0, AW'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 19) == 0,
               m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
               DW'($urandom), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
